// File: rtl/ks_pkg.sv
// Shared types, default sizes and the period clamp for the plucked-string sequencer.
package ks_pkg;

   localparam int unsigned KS_ADDR_W      = 10;
   localparam int unsigned KS_DEPTH       = 656;
   localparam int unsigned KS_MIN_PERIOD  = 2;
   localparam int unsigned KS_SUSTAIN_MAX = 48000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_EXCITE,
      ST_SUSTAIN
   } ks_state_t;

   // Limit a requested period to the range the delay line can physically hold.
   function automatic int unsigned ks_clamp_period(input int unsigned p,
                                                   input int unsigned min_p,
                                                   input int unsigned max_p);
      if (p < min_p) return min_p;
      if (p > max_p) return max_p;
      return p;
   endfunction

endpackage

// File: rtl/ks_pluck_ctrl_if.sv
// Request/response and delay-line control bundle between a voice host and the pluck sequencer.
interface ks_pluck_ctrl_if
   import ks_pkg::*;
#(
   parameter int unsigned ADDR_W = KS_ADDR_W
);
   logic              sample_tick;
   logic              note_on;
   logic [ADDR_W-1:0] period;
   logic              note_off;
   logic              ready;
   logic              voice_active;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              trigger;
   logic              clr;

   modport master (
      output sample_tick, note_on, period, note_off,
      input  ready, voice_active, wr_en, wr_addr, rd_addr, trigger, clr
   );

   modport slave (
      input  sample_tick, note_on, period, note_off,
      output ready, voice_active, wr_en, wr_addr, rd_addr, trigger, clr
   );
endinterface

// File: rtl/ks_mod_counter.sv
// Enable-driven modulo counter with synchronous clear; wrap flags the last value before zero.
module ks_mod_counter #(
   parameter int unsigned W = 10
) (
   input  logic         m_clk,
   input  logic         aclr_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] modv,
   output logic [W-1:0] count,
   output logic         wrap
);

   assign wrap = (count == modv - W'(1));

   always_ff @(posedge m_clk or negedge aclr_n) begin
      if (!aclr_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/ks_pluck_ctrl.sv
// Plucked-string delay-line sequencer: clear the line, inject one lap of noise,
// then run filter feedback until release or sustain timeout.
module ks_pluck_ctrl
   import ks_pkg::*;
#(
   parameter int unsigned ADDR_W      = KS_ADDR_W,
   parameter int unsigned DEPTH       = KS_DEPTH,
   parameter int unsigned MIN_PERIOD  = KS_MIN_PERIOD,
   parameter int unsigned SUSTAIN_MAX = KS_SUSTAIN_MAX
) (
   input  logic          m_clk,
   input  logic          aclr_n,
   ks_pluck_ctrl_if.slave bus
);

   localparam int unsigned SUS_W = $clog2(SUSTAIN_MAX + 1);

   ks_state_t         state_q, state_nxt;
   logic [ADDR_W-1:0] period_q, period_nxt;
   logic              pend_off_q, pend_off_nxt;
   logic              ready_q, ready_nxt;
   logic              active_q, active_nxt;
   logic              wr_en_q, wr_en_nxt;
   logic              trigger_q, trigger_nxt;
   logic              clr_q, clr_nxt;

   logic              accept;
   logic              ptr_en, ptr_clr, ptr_wrap;
   logic [ADDR_W-1:0] ptr, ptr_mod;
   logic              sus_en, sus_clr, sus_wrap;
   logic [SUS_W-1:0]  sus_cnt;

   assign accept  = bus.note_on && (state_q == ST_IDLE || state_q == ST_SUSTAIN);
   // One pointer serves both the clear sweep and the circular write/read position.
   assign ptr_mod = (state_q == ST_CLEAR) ? ADDR_W'(DEPTH) : period_q;

   ks_mod_counter #(.W(ADDR_W)) u_ptr (
      .m_clk  (m_clk),
      .aclr_n (aclr_n),
      .clr    (ptr_clr),
      .en     (ptr_en),
      .modv   (ptr_mod),
      .count  (ptr),
      .wrap   (ptr_wrap)
   );

   ks_mod_counter #(.W(SUS_W)) u_sus (
      .m_clk  (m_clk),
      .aclr_n (aclr_n),
      .clr    (sus_clr),
      .en     (sus_en),
      .modv   (SUS_W'(SUSTAIN_MAX)),
      .count  (sus_cnt),
      .wrap   (sus_wrap)
   );

   // Sustain count is cleared on entry and retires the voice at its last value.
   always_comb begin
      if (state_q == ST_SUSTAIN) assert (sus_cnt < SUS_W'(SUSTAIN_MAX));
   end

   // Next state; the pointer only advances on real writes and freezes on release.
   always_comb begin
      state_nxt    = state_q;
      period_nxt   = period_q;
      pend_off_nxt = pend_off_q;
      ptr_en       = 1'b0;
      ptr_clr      = 1'b0;
      sus_en       = 1'b0;
      sus_clr      = 1'b0;

      unique case (state_q)
         ST_IDLE: ;
         ST_CLEAR: begin
            ptr_en = 1'b1;
            if (bus.note_off) pend_off_nxt = 1'b1;
            if (ptr_wrap)     state_nxt    = ST_EXCITE;
         end
         ST_EXCITE: begin
            if (bus.note_off) pend_off_nxt = 1'b1;
            if (wr_en_q && ptr_wrap) begin
               if (pend_off_nxt) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_SUSTAIN;
                  sus_clr   = 1'b1;
                  ptr_en    = 1'b1;
               end
            end else begin
               ptr_en = wr_en_q;
            end
         end
         ST_SUSTAIN: begin
            if (bus.note_off) begin
               state_nxt = ST_IDLE;
            end else if (wr_en_q) begin
               sus_en = 1'b1;
               if (sus_wrap) state_nxt = ST_IDLE;
               else          ptr_en    = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (accept) begin
         state_nxt    = ST_CLEAR;
         period_nxt   = ADDR_W'(ks_clamp_period(32'(bus.period), MIN_PERIOD, DEPTH));
         pend_off_nxt = 1'b0;
         ptr_clr      = 1'b1;
      end

      wr_en_nxt   = 1'b0;
      trigger_nxt = 1'b0;
      clr_nxt     = 1'b0;
      unique case (state_nxt)
         ST_CLEAR: begin
            wr_en_nxt = 1'b1;
            clr_nxt   = 1'b1;
         end
         ST_EXCITE: begin
            trigger_nxt = 1'b1;
            wr_en_nxt   = bus.sample_tick && (state_q != ST_CLEAR);
         end
         ST_SUSTAIN: wr_en_nxt = bus.sample_tick;
         default: ;
      endcase

      ready_nxt  = (state_nxt == ST_IDLE)   || (state_nxt == ST_SUSTAIN);
      active_nxt = (state_nxt == ST_EXCITE) || (state_nxt == ST_SUSTAIN);
   end

   always_ff @(posedge m_clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q    <= ST_IDLE;
         period_q   <= ADDR_W'(MIN_PERIOD);
         pend_off_q <= 1'b0;
         ready_q    <= 1'b1;
         active_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         trigger_q  <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         period_q   <= period_nxt;
         pend_off_q <= pend_off_nxt;
         ready_q    <= ready_nxt;
         active_q   <= active_nxt;
         wr_en_q    <= wr_en_nxt;
         trigger_q  <= trigger_nxt;
         clr_q      <= clr_nxt;
      end
   end

   assign bus.ready        = ready_q;
   assign bus.voice_active = active_q;
   assign bus.wr_en        = wr_en_q;
   assign bus.trigger      = trigger_q;
   assign bus.clr          = clr_q;
   assign bus.wr_addr      = ptr;
   assign bus.rd_addr      = ptr;

endmodule

// File: tb/tb_ks_pluck_ctrl.sv
// Self-checking bench for ks_pluck_ctrl: randomized tick spacing and periods against a lap-based write model.
module tb_ks_pluck_ctrl;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 656;
   localparam int unsigned MINP  = 2;
   localparam int unsigned SMAX  = 1000;

   logic m_clk  = 1'b0;
   logic aclr_n = 1'b0;
   int   tests  = 0;
   int   fails  = 0;

   always #5 m_clk = ~m_clk;

   ks_pluck_ctrl_if #(.ADDR_W(AW)) bus ();

   ks_pluck_ctrl #(
      .ADDR_W      (AW),
      .DEPTH       (DEPTH),
      .MIN_PERIOD  (MINP),
      .SUSTAIN_MAX (SMAX)
   ) u_dut (
      .m_clk  (m_clk),
      .aclr_n (aclr_n),
      .bus    (bus)
   );

   task automatic cyc();
      @(posedge m_clk);
      #1;
   endtask

   function automatic int unsigned model_period(input int unsigned p);
      if (p < MINP)  return MINP;
      if (p > DEPTH) return DEPTH;
      return p;
   endfunction

   // One sample tick followed by 1..3 quiet cycles; reports the write it produced.
   task automatic tick_once(output bit we, output int unsigned a, output int unsigned ar,
                            output bit tr, output bit cl, output bit spur);
      bus.sample_tick = 1'b1;
      cyc();
      bus.sample_tick = 1'b0;
      we   = bus.wr_en;
      a    = 32'(bus.wr_addr);
      ar   = 32'(bus.rd_addr);
      tr   = bus.trigger;
      cl   = bus.clr;
      spur = 1'b0;
      repeat ($urandom_range(1, 3)) begin
         cyc();
         if (bus.wr_en) spur = 1'b1;
      end
   endtask

   task automatic note_off_pulse();
      bus.note_off = 1'b1;
      cyc();
      bus.note_off = 1'b0;
   endtask

   // Pluck with period p, check the clear sweep, one noise lap, then sus_ticks feedback writes.
   task automatic run_note(input int unsigned p, input bit with_off, input bit off_in_excite,
                           input int unsigned sus_ticks);
      int unsigned mp, bad_i, bad_a, a, ar;
      bit ok, we, tr, cl, sp, bad_we, bad_tr;
      mp = model_period(p);

      tests++;
      if (bus.ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_before_pluck p=%0d: got %b want 1", p, bus.ready);
      end

      bus.period   = AW'(p);
      bus.note_on  = 1'b1;
      bus.note_off = with_off;
      cyc();
      bus.note_on  = 1'b0;
      bus.note_off = 1'b0;
      bus.period   = AW'($urandom);

      ok = 1'b1; bad_i = 0; bad_a = 0; bad_we = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ok && !(bus.clr === 1'b1 && bus.wr_en === 1'b1 && bus.trigger === 1'b0 &&
                     bus.ready === 1'b0 && 32'(bus.wr_addr) == i)) begin
            ok = 1'b0; bad_i = i; bad_a = 32'(bus.wr_addr); bad_we = bus.wr_en;
         end
         bus.sample_tick = 1'($urandom);
         if (i == DEPTH / 2) bus.note_on = 1'b1;
         cyc();
         bus.note_on = 1'b0;
      end
      bus.sample_tick = 1'b0;
      tests++;
      if (ok !== 1'b1) begin
         fails++;
         $display("FAIL clear_sweep p=%0d: word %0d got addr %0d wr_en %b, want addr %0d wr_en 1 clr 1",
                  p, bad_i, bad_a, bad_we, bad_i);
      end

      tests++;
      if ({bus.wr_en, bus.trigger, bus.clr, bus.voice_active, bus.ready} !== 5'b01010) begin
         fails++;
         $display("FAIL excite_entry: got we/trig/clr/active/ready=%b%b%b%b%b want 01010",
                  bus.wr_en, bus.trigger, bus.clr, bus.voice_active, bus.ready);
      end

      ok = 1'b1; bad_i = 0; bad_a = 0; bad_we = 1'b0; bad_tr = 1'b0;
      for (int unsigned k = 0; k < mp; k++) begin
         if (off_in_excite && k == mp / 2) note_off_pulse();
         if (k == 1) begin
            bus.period  = AW'($urandom);
            bus.note_on = 1'b1;
            cyc();
            bus.note_on = 1'b0;
         end
         tick_once(we, a, ar, tr, cl, sp);
         if (ok && !(we && tr && !cl && !sp && a == k && ar == k)) begin
            ok = 1'b0; bad_i = k; bad_a = a; bad_we = we; bad_tr = tr;
         end
      end
      tests++;
      if (ok !== 1'b1) begin
         fails++;
         $display("FAIL noise_lap p=%0d: tick %0d got addr %0d we %b trig %b, want addr %0d we 1 trig 1",
                  mp, bad_i, bad_a, bad_we, bad_tr, bad_i);
      end

      if (off_in_excite) begin
         tests++;
         if ({bus.voice_active, bus.ready} !== 2'b01) begin
            fails++;
            $display("FAIL release_after_lap: got active/ready=%b%b want 01",
                     bus.voice_active, bus.ready);
         end
         tick_once(we, a, ar, tr, cl, sp);
         tests++;
         if ({we, sp} !== 2'b00) begin
            fails++;
            $display("FAIL no_sustain_write: got wr_en %b want 0", we);
         end
      end else begin
         tests++;
         if ({bus.voice_active, bus.ready, bus.trigger} !== 3'b110) begin
            fails++;
            $display("FAIL sustain_entry: got active/ready/trig=%b%b%b want 110",
                     bus.voice_active, bus.ready, bus.trigger);
         end
         if (sus_ticks > 0) begin
            ok = 1'b1; bad_i = 0; bad_a = 0; bad_we = 1'b0; bad_tr = 1'b0;
            for (int unsigned j = 0; j < sus_ticks; j++) begin
               tick_once(we, a, ar, tr, cl, sp);
               if (ok && !(we && !tr && !cl && !sp && a == j % mp)) begin
                  ok = 1'b0; bad_i = j; bad_a = a; bad_we = we; bad_tr = tr;
               end
            end
            tests++;
            if (ok !== 1'b1) begin
               fails++;
               $display("FAIL feedback p=%0d: tick %0d got addr %0d we %b trig %b, want addr %0d we 1 trig 0",
                        mp, bad_i, bad_a, bad_we, bad_tr, bad_i % mp);
            end
         end
      end
   endtask

   task automatic check_idle(input string tag);
      tests++;
      if ({bus.voice_active, bus.ready, bus.wr_en, bus.trigger, bus.clr} !== 5'b01000) begin
         fails++;
         $display("FAIL %s: got active/ready/we/trig/clr=%b%b%b%b%b want 01000", tag,
                  bus.voice_active, bus.ready, bus.wr_en, bus.trigger, bus.clr);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      tests++;
      if ({bus.ready, bus.voice_active, bus.wr_en, bus.trigger, bus.clr} !== 5'b10000 ||
          bus.wr_addr !== '0 || bus.rd_addr !== '0) begin
         fails++;
         $display("FAIL %s: got ready/active/we/trig/clr=%b%b%b%b%b wa=%0d ra=%0d want 10000 0 0", tag,
                  bus.ready, bus.voice_active, bus.wr_en, bus.trigger, bus.clr,
                  bus.wr_addr, bus.rd_addr);
      end
   endtask

   task automatic test_reset();
      repeat (3) cyc();
      check_reset_vals("reset_held");
      aclr_n = 1'b1;
      cyc();
      check_reset_vals("reset_released");
   endtask

   task automatic test_pluck();
      bit we, tr, cl, sp;
      int unsigned a, ar;
      run_note(100, 1'b0, 1'b0, 1);
      note_off_pulse();
      check_idle("note_off_sustain");
      note_off_pulse();
      check_idle("note_off_idle");
      tick_once(we, a, ar, tr, cl, sp);
      tests++;
      if ({we, sp} !== 2'b00) begin
         fails++;
         $display("FAIL idle_tick: got wr_en %b want 0", we);
      end
   endtask

   task automatic test_period_clamp();
      run_note(0, 1'b0, 1'b0, 2);
      run_note(1000, 1'b0, 1'b0, 1);
      repeat (2) run_note($urandom_range(0, 1023), 1'b0, 1'b0, 3);
      note_off_pulse();
      check_idle("clamp_release");
   endtask

   task automatic test_off_in_excite();
      run_note(100, 1'b0, 1'b1, 0);
   endtask

   task automatic test_retrigger();
      run_note(100, 1'b0, 1'b0, 3);
      run_note(50, 1'b0, 1'b0, 2);
      note_off_pulse();
      check_idle("retrigger_release");
   endtask

   task automatic test_timeout();
      bit we, tr, cl, sp;
      int unsigned a, ar, mp;
      mp = model_period($urandom_range(2, 40));
      run_note(mp, 1'b0, 1'b0, SMAX - 1);
      tick_once(we, a, ar, tr, cl, sp);
      tests++;
      if (we !== 1'b1 || a != (SMAX - 1) % mp) begin
         fails++;
         $display("FAIL timeout_last_write: got we %b addr %0d want we 1 addr %0d", we, a, (SMAX - 1) % mp);
      end
      check_idle("timeout_idle");
      tick_once(we, a, ar, tr, cl, sp);
      tests++;
      if ({we, sp} !== 2'b00) begin
         fails++;
         $display("FAIL timeout_no_write: got wr_en %b want 0", we);
      end
   endtask

   task automatic test_on_off_same();
      run_note(20, 1'b0, 1'b0, 1);
      run_note(30, 1'b1, 1'b0, 2);
      note_off_pulse();
      check_idle("on_off_release");
   endtask

   task automatic test_async_reset();
      bit we, tr, cl, sp, any_we;
      int unsigned a, ar;
      bus.period  = AW'(100);
      bus.note_on = 1'b1;
      cyc();
      bus.note_on = 1'b0;
      repeat (DEPTH) cyc();
      repeat (5) tick_once(we, a, ar, tr, cl, sp);
      aclr_n = 1'b0;
      #2;
      check_reset_vals("async_reset_immediate");
      cyc();
      aclr_n = 1'b1;
      any_we = 1'b0;
      repeat (4) begin
         tick_once(we, a, ar, tr, cl, sp);
         any_we = any_we | we | sp;
      end
      tests++;
      if (any_we !== 1'b0 || bus.voice_active !== 1'b0 || bus.ready !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_quiet: got write %b active %b ready %b want 0 0 1",
                  any_we, bus.voice_active, bus.ready);
      end
   endtask

   initial begin
      bus.sample_tick = 1'b0;
      bus.note_on     = 1'b0;
      bus.note_off    = 1'b0;
      bus.period      = '0;
      test_reset();
      test_pluck();
      test_period_clamp();
      test_off_in_excite();
      test_retrigger();
      test_timeout();
      test_on_off_same();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
